clock_switch_sequencer: RTL and testbench

Sequencer that drives the clock-select controls of the chip clocking block (ext_clk_sel, sel, sel2). It measures the PLL against ext_clk before allowing a switch, applies divider values while still on the external clock, and then moves to the PLL. It keeps monitoring the PLL afterwards and falls back to ext_clk if the PLL frequency drops. It runs entirely on the always-present external pad clock and sits between housekeeping configuration registers and the clocking block.

---
 rtl/clock_switch_sequencer.sv | 162 ++++++++++++++++
 tb/tb_clock_switch_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_switch_sequencer.sv
// Clock-source sequencer: qualifies the PLL against ext_clk, applies dividers on ext_clk,
// switches to the PLL and falls back to ext_clk when the PLL frequency drops.
module clock_switch_sequencer #(
    parameter int WINDOW = 256,
    parameter int SETTLE = 16,
    parameter int CNT_W  = 12
) (
    input  logic             ext_clk,
    input  logic             reset,
    input  logic             req_pll,
    input  logic [2:0]       sel_req,
    input  logic [2:0]       sel2_req,
    input  logic [CNT_W-1:0] min_count,
    input  logic             pll_probe,
    output logic             ext_clk_sel,
    output logic [2:0]       sel,
    output logic [2:0]       sel2,
    output logic             pll_ok,
    output logic             busy,
    output logic             fail,
    output logic [CNT_W-1:0] last_count
);

    localparam int WIN_W = $clog2(WINDOW);
    localparam int SET_W = $clog2(SETTLE + 1);

    localparam logic [2:0] IDLE_EXT = 3'd0;
    localparam logic [2:0] MEASURE  = 3'd1;
    localparam logic [2:0] DIVSET   = 3'd2;
    localparam logic [2:0] SWITCH   = 3'd3;
    localparam logic [2:0] RUN_PLL  = 3'd4;
    localparam logic [2:0] HOLD     = 3'd5;

    logic [2:0]       state;
    logic             probe_s1, probe_s2, probe_d;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic [SET_W-1:0] settle_cnt;

    logic             rise;
    logic             win_last;
    logic             win_pass;
    logic [CNT_W-1:0] cnt_final;

    // cnt_final already includes an edge seen on the current cycle, so the
    // last cycle of a window contributes to that window.
    always_comb begin
        rise      = probe_s2 & ~probe_d;
        cnt_final = (rise && edge_cnt != {CNT_W{1'b1}}) ? edge_cnt + 1'b1 : edge_cnt;
        win_last  = (win_cnt == WIN_W'(WINDOW - 1));
        win_pass  = (cnt_final >= min_count);
    end

    always_ff @(posedge ext_clk) begin
        if (reset) begin
            state       <= IDLE_EXT;
            probe_s1    <= 1'b0;
            probe_s2    <= 1'b0;
            probe_d     <= 1'b0;
            win_cnt     <= '0;
            edge_cnt    <= '0;
            settle_cnt  <= '0;
            ext_clk_sel <= 1'b1;
            sel         <= 3'd0;
            sel2        <= 3'd0;
            pll_ok      <= 1'b0;
            busy        <= 1'b0;
            fail        <= 1'b0;
            last_count  <= '0;
        end else begin
            probe_s1 <= pll_probe;
            probe_s2 <= probe_s1;
            probe_d  <= probe_s2;
            case (state)
                IDLE_EXT: begin
                    ext_clk_sel <= 1'b1;
                    pll_ok      <= 1'b0;
                    if (req_pll) begin
                        state    <= MEASURE;
                        fail     <= 1'b0;
                        busy     <= 1'b1;
                        win_cnt  <= '0;
                        edge_cnt <= '0;
                    end
                end
                MEASURE: begin
                    if (!req_pll) begin
                        state <= IDLE_EXT;
                        busy  <= 1'b0;
                    end else begin
                        win_cnt  <= win_last ? '0 : win_cnt + 1'b1;
                        edge_cnt <= win_last ? '0 : cnt_final;
                        if (win_last) begin
                            last_count <= cnt_final;
                            if (win_pass) begin
                                state      <= DIVSET;
                                settle_cnt <= '0;
                            end else begin
                                state <= HOLD;
                                fail  <= 1'b1;
                                busy  <= 1'b0;
                            end
                        end
                    end
                end
                DIVSET: begin
                    // First DIVSET cycle latches the dividers; SETTLE more cycles follow.
                    if (settle_cnt == '0) begin
                        sel  <= sel_req;
                        sel2 <= sel2_req;
                    end
                    settle_cnt <= settle_cnt + 1'b1;
                    if (!req_pll) begin
                        state <= IDLE_EXT;
                        busy  <= 1'b0;
                    end else if (settle_cnt == SET_W'(SETTLE)) begin
                        state <= SWITCH;
                    end
                end
                SWITCH: begin
                    ext_clk_sel <= 1'b0;
                    pll_ok      <= 1'b1;
                    busy        <= 1'b0;
                    state       <= RUN_PLL;
                    win_cnt     <= '0;
                    edge_cnt    <= '0;
                end
                RUN_PLL: begin
                    win_cnt  <= win_last ? '0 : win_cnt + 1'b1;
                    edge_cnt <= win_last ? '0 : cnt_final;
                    // A failing window outranks a simultaneous request drop.
                    if (win_last && !win_pass) begin
                        last_count  <= cnt_final;
                        fail        <= 1'b1;
                        ext_clk_sel <= 1'b1;
                        pll_ok      <= 1'b0;
                        state       <= HOLD;
                    end else if (!req_pll) begin
                        ext_clk_sel <= 1'b1;
                        pll_ok      <= 1'b0;
                        state       <= IDLE_EXT;
                    end else if (win_last) begin
                        last_count <= cnt_final;
                    end
                end
                HOLD: begin
                    ext_clk_sel <= 1'b1;
                    pll_ok      <= 1'b0;
                    busy        <= 1'b0;
                    if (!req_pll) state <= IDLE_EXT;
                end
                default: begin
                    state       <= IDLE_EXT;
                    ext_clk_sel <= 1'b1;
                    pll_ok      <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_switch_sequencer.sv
// Bench for clock_switch_sequencer: directed scenarios, an edge-history reference model
// checked every cycle, and literal expectations at the documented edges.
module tb_clock_switch_sequencer;

    localparam int W   = 256;
    localparam int S   = 16;
    localparam int CW  = 12;
    localparam int SW_ = 48;
    localparam int SS  = 4;
    localparam int MAXE = 20000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_pll = 1'b0;
    logic [2:0]    sel_req = 3'd0;
    logic [2:0]    sel2_req = 3'd0;
    logic [CW-1:0] min_count = '0;
    logic          pll_probe = 1'b0;
    logic          ext_clk_sel, pll_ok, busy, fail;
    logic [2:0]    sel, sel2;
    logic [CW-1:0] last_count;

    logic          s_req = 1'b0;
    logic [3:0]    s_min = 4'd15;
    logic          s_ext, s_ok, s_busy, s_fail;
    logic [2:0]    s_sel, s_sel2;
    logic [3:0]    s_last;

    bit probe_on = 1'b1;
    int tests = 0;
    int fails = 0;

    clock_switch_sequencer #(.WINDOW(W), .SETTLE(S), .CNT_W(CW)) dut (
        .ext_clk(clk), .reset(reset), .req_pll(req_pll), .sel_req(sel_req),
        .sel2_req(sel2_req), .min_count(min_count), .pll_probe(pll_probe),
        .ext_clk_sel(ext_clk_sel), .sel(sel), .sel2(sel2), .pll_ok(pll_ok),
        .busy(busy), .fail(fail), .last_count(last_count));

    clock_switch_sequencer #(.WINDOW(SW_), .SETTLE(SS), .CNT_W(4)) dut_small (
        .ext_clk(clk), .reset(reset), .req_pll(s_req), .sel_req(sel_req),
        .sel2_req(sel2_req), .min_count(s_min), .pll_probe(pll_probe),
        .ext_clk_sel(s_ext), .sel(s_sel), .sel2(s_sel2), .pll_ok(s_ok),
        .busy(s_busy), .fail(s_fail), .last_count(s_last));

    always #5 clk = ~clk;

    // probe: period of two ext_clk cycles when running, otherwise held low
    always @(negedge clk) pll_probe = probe_on ? ~pll_probe : 1'b0;

    // ---------------- reference model ----------------
    localparam int P_IDLE = 0, P_MEAS = 1, P_DIV = 2, P_SW = 3, P_RUN = 4, P_HOLD = 5;
    bit            p [0:MAXE-1];
    int            e = -1;
    int            ph, ws, d0;
    bit            started = 1'b0;
    logic          m_ext, m_ok, m_busy, m_fail;
    logic [2:0]    m_sel, m_sel2;
    logic [CW-1:0] m_last;

    // rising edge seen by the counter on edge k: raw sample two edges back high, three back low
    function automatic int rise_at(input int k);
        if (k < 3) return 0;
        return (p[k-2] && !p[k-3]) ? 1 : 0;
    endfunction

    function automatic int win_count(input int a, input int b);
        int n = 0;
        for (int k = a; k <= b; k++) n += rise_at(k);
        if (n > (1 << CW) - 1) n = (1 << CW) - 1;
        return n;
    endfunction

    always @(posedge clk) begin
        int c;
        e++;
        p[e] = pll_probe;
        if (reset) begin
            ph = P_IDLE; started = 1'b1;
            m_ext = 1'b1; m_ok = 1'b0; m_busy = 1'b0; m_fail = 1'b0;
            m_sel = 3'd0; m_sel2 = 3'd0; m_last = '0;
            p[e] = 1'b0;
            if (e >= 1) p[e-1] = 1'b0;
            if (e >= 2) p[e-2] = 1'b0;
        end else if (started) begin
            case (ph)
                P_IDLE: if (req_pll) begin
                    ph = P_MEAS; ws = e + 1; m_fail = 1'b0; m_busy = 1'b1;
                end
                P_MEAS: begin
                    if (!req_pll) begin
                        ph = P_IDLE; m_busy = 1'b0;
                    end else if (e == ws + W - 1) begin
                        c = win_count(ws, e);
                        m_last = CW'(c);
                        if (c >= int'(min_count)) begin
                            ph = P_DIV; d0 = e + 1;
                        end else begin
                            ph = P_HOLD; m_fail = 1'b1; m_busy = 1'b0;
                        end
                    end
                end
                P_DIV: begin
                    if (e == d0) begin m_sel = sel_req; m_sel2 = sel2_req; end
                    if (!req_pll) begin ph = P_IDLE; m_busy = 1'b0; end
                    else if (e == d0 + S) ph = P_SW;
                end
                P_SW: begin
                    ph = P_RUN; ws = e + 1; m_ext = 1'b0; m_ok = 1'b1; m_busy = 1'b0;
                end
                P_RUN: begin
                    c = (e == ws + W - 1) ? win_count(ws, e) : 0;
                    if (e == ws + W - 1 && c < int'(min_count)) begin
                        m_last = CW'(c); m_fail = 1'b1; m_ext = 1'b1; m_ok = 1'b0; ph = P_HOLD;
                    end else if (!req_pll) begin
                        m_ext = 1'b1; m_ok = 1'b0; ph = P_IDLE;
                    end else if (e == ws + W - 1) begin
                        m_last = CW'(c); ws = e + 1;
                    end
                end
                default: if (!req_pll) ph = P_IDLE;
            endcase
        end
        #1;
        if (started) begin
            tests++;
            if ({ext_clk_sel, sel, sel2, pll_ok, busy, fail, last_count} !==
                {m_ext, m_sel, m_sel2, m_ok, m_busy, m_fail, m_last}) begin
                fails++;
                $display("FAIL model edge %0d: got ext=%b sel=%0d sel2=%0d ok=%b busy=%b fail=%b last=%0d, want ext=%b sel=%0d sel2=%0d ok=%b busy=%b fail=%b last=%0d",
                         e, ext_clk_sel, sel, sel2, pll_ok, busy, fail, last_count,
                         m_ext, m_sel, m_sel2, m_ok, m_busy, m_fail, m_last);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    initial begin
        step(3);
        reset = 1'b0;
        chk("reset ext_clk_sel", ext_clk_sel, 1);
        chk("reset sel", sel, 0);
        chk("reset pll_ok", pll_ok, 0);
        chk("reset busy", busy, 0);
        chk("reset last_count", last_count, 0);
        step(2);

        // good PLL: 128 edges per window, switch at edge 274
        min_count = 100; sel_req = 3; sel2_req = 5; req_pll = 1'b1;
        step(1);
        step(1);   chk("good busy@1", busy, 1);
        step(255); chk("good last_count@256", last_count, 128);
                   chk("good sel before divset", sel, 0);
        step(1);   chk("good sel@257", sel, 3);
                   chk("good sel2@257", sel2, 5);
        step(16);  chk("good busy@273", busy, 1);
                   chk("good ext@273", ext_clk_sel, 1);
        step(1);   chk("good ext@274", ext_clk_sel, 0);
                   chk("good pll_ok@274", pll_ok, 1);
                   chk("good busy@274", busy, 0);

        // boundary: min_count equal to count passes, one above fails
        min_count = 128; sel_req = 7;
        step(300); chk("min==count pll_ok", pll_ok, 1);
                   chk("min==count last", last_count, 128);
                   chk("sel_req ignored in run", sel, 3);
        min_count = 129;
        step(260); chk("min>count fail", fail, 1);
                   chk("min>count ext", ext_clk_sel, 1);
        req_pll = 1'b0;
        step(2);

        // PLL loss while running
        min_count = 100; sel_req = 3; sel2_req = 5; req_pll = 1'b1;
        step(275); chk("loss pre pll_ok", pll_ok, 1);
        probe_on = 1'b0; sel_req = 7;
        step(2 * W); chk("loss ext", ext_clk_sel, 1);
                   chk("loss pll_ok", pll_ok, 0);
                   chk("loss fail", fail, 1);
                   chk("loss sel kept", sel, 3);
        req_pll = 1'b0;
        step(2);

        // dead PLL, then re-request
        req_pll = 1'b1;
        step(1);   chk("dead fail cleared", fail, 0);
        step(256); chk("dead last_count", last_count, 0);
                   chk("dead fail", fail, 1);
                   chk("dead busy (hold)", busy, 0);
                   chk("dead ext", ext_clk_sel, 1);
        step(5);   chk("hold ext", ext_clk_sel, 1);
        req_pll = 1'b0;
        step(2);   chk("idle fail sticky", fail, 1);
        probe_on = 1'b1; req_pll = 1'b1;
        step(1);   chk("retry fail cleared", fail, 0);
                   chk("retry busy", busy, 1);

        // abort at cycle 100 of MEASURE
        step(99);
        req_pll = 1'b0;
        step(1);   chk("abort busy", busy, 0);
                   chk("abort last_count", last_count, 0);
                   chk("abort fail", fail, 0);
                   chk("abort sel", sel, 3);
        step(2);

        // abort during DIVSET
        sel_req = 6; sel2_req = 2; req_pll = 1'b1;
        step(1);
        step(260); chk("divabort sel new", sel, 6);
                   chk("divabort busy", busy, 1);
        req_pll = 1'b0;
        step(1);   chk("divabort busy off", busy, 0);
        step(20);  chk("divabort ext", ext_clk_sel, 1);
                   chk("divabort pll_ok", pll_ok, 0);
                   chk("divabort sel2", sel2, 2);

        // reset mid RUN_PLL
        req_pll = 1'b1;
        step(275); chk("prereset pll_ok", pll_ok, 1);
        reset = 1'b1; req_pll = 1'b0;
        step(1);   chk("rst ext", ext_clk_sel, 1);
                   chk("rst sel", sel, 0);
                   chk("rst sel2", sel2, 0);
                   chk("rst pll_ok", pll_ok, 0);
                   chk("rst fail", fail, 0);
                   chk("rst last_count", last_count, 128 - 128);
        reset = 1'b0;
        step(2);

        // saturation: 24 edges in a 48-cycle window into a 4-bit counter
        sel_req = 4; sel2_req = 1; s_req = 1'b1;
        step(1);
        step(SW_); chk("sat last_count", s_last, 15);
                   chk("sat fail", s_fail, 0);
        step(SS + 2); chk("sat ext", s_ext, 0);
                   chk("sat pll_ok", s_ok, 1);
                   chk("sat sel", s_sel, 4);
        s_req = 1'b0;
        step(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
